// File: rtl/row_column_feeder.sv
// Ping-pong transpose buffer: row beats in (valid/ready), column beats out (no backpressure).
// Two banks each hold one complete matrix set; the per-bank full flag hands a bank from writer to reader.
module row_column_feeder #(
  parameter int N_MATS     = 10,
  parameter int DATA_WIDTH = 16,
  parameter int MAT_HEIGHT = 2,
  parameter int MAT_WIDTH  = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [N_MATS-1:0][MAT_WIDTH-1:0][DATA_WIDTH-1:0]  in_row,
  output logic                                             valid_out,
  output logic [N_MATS-1:0][MAT_HEIGHT-1:0][DATA_WIDTH-1:0] column_out,
  output logic                                             last_out
);

  localparam int RW = (MAT_HEIGHT > 1) ? $clog2(MAT_HEIGHT) : 1;
  localparam int CW = $clog2(MAT_WIDTH);

  typedef logic [N_MATS-1:0][MAT_WIDTH-1:0][DATA_WIDTH-1:0]  row_t;
  typedef logic [N_MATS-1:0][MAT_HEIGHT-1:0][DATA_WIDTH-1:0] col_t;
  typedef enum logic {IDLE, STREAM} state_t;

  row_t          mem_q [2][MAT_HEIGHT];
  logic [1:0]    full_q;
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [RW-1:0] wr_row_q;
  logic [CW-1:0] rd_col_q;
  state_t        state_q;

  col_t col_d;
  logic wr_acc;
  logic wr_last;
  logic rd_go;
  logic rd_last;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_acc   = in_valid && in_ready;
  assign wr_last  = (wr_row_q == RW'(MAT_HEIGHT - 1));
  // IDLE emits column 0 on the edge it sees a full bank, so the flag is always one cycle old.
  assign rd_go    = (state_q == STREAM) || full_q[rd_bank_q];
  assign rd_last  = rd_go && (rd_col_q == CW'(MAT_WIDTH - 1));

  always_comb begin
    col_d = '0;
    for (int unsigned m = 0; m < N_MATS; m++) begin
      for (int unsigned r = 0; r < MAT_HEIGHT; r++) begin
        col_d[m][r] = mem_q[rd_bank_q][r][m][rd_col_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_bank_q][wr_row_q] <= in_row;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_col_q   <= '0;
      state_q    <= IDLE;
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      column_out <= '0;
    end else begin
      if (wr_acc) begin
        if (wr_last) begin
          full_q[wr_bank_q] <= 1'b1;
          wr_bank_q         <= ~wr_bank_q;
          wr_row_q          <= '0;
        end else begin
          wr_row_q <= wr_row_q + 1'b1;
        end
      end

      if (rd_go) begin
        column_out <= col_d;
        valid_out  <= 1'b1;
        last_out   <= rd_last;
        if (rd_last) begin
          full_q[rd_bank_q] <= 1'b0;
          rd_bank_q         <= ~rd_bank_q;
          rd_col_q          <= '0;
          state_q           <= full_q[~rd_bank_q] ? STREAM : IDLE;
        end else begin
          rd_col_q <= rd_col_q + 1'b1;
          state_q  <= STREAM;
        end
      end else begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
        rd_col_q  <= '0;
        state_q   <= IDLE;
      end
    end
  end

endmodule

// File: doc/row_column_feeder.md
# row_column_feeder

Transpose buffer feeding the decision-stage column reducers. Accepts one row per cycle for each of N_MATS small matrices (row-major, as produced by the preceding pooling stage), stores complete matrix sets in a two-bank ping-pong buffer, and emits them column by column. Each output beat carries MAT_HEIGHT elements per matrix and a shared valid, which is exactly the shape the reducer array consumes. The output side has no backpressure because the reducers are always ready. The input side is throttled with a valid/ready handshake.

## Interface
- N_MATS, 10, number of matrices handled in parallel
- DATA_WIDTH, 16, element width in bits
- MAT_HEIGHT, 2, rows per matrix (elements per output column)
- MAT_WIDTH, 4, columns per matrix (output beats per matrix set); ≥2
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_row holds a valid row beat
- in_ready  output  1  feeder can accept a row beat this cycle
- in_row  input  [DATA_WIDTH-1:0] [N_MATS-1:0][MAT_WIDTH]  row r of every matrix; element [m][c]
- valid_out  output  1  column_out holds a valid column beat
- column_out  output  [DATA_WIDTH-1:0] [N_MATS-1:0][MAT_HEIGHT]  column c of every matrix; element [m][r]
- last_out  output  1  high with the final column (c = MAT_WIDTH-1) of a matrix set

## Operation
- Storage: two banks, each holding N_MATS × MAT_HEIGHT × MAT_WIDTH elements, with a full flag per bank.
- Write side:
  - Counters wr_bank (1 bit) and wr_row (0..MAT_HEIGHT-1).
  - Accept occurs when in_valid && in_ready. On accept, in_row is stored at row wr_row of bank wr_bank.
  - On the accept with wr_row = MAT_HEIGHT-1: set full[wr_bank], toggle wr_bank, clear wr_row. Otherwise wr_row increments.
- in_ready = !full[wr_bank]. It is combinational from registers only and has no dependence on in_valid.
- Read side FSM states:
  - IDLE: rd_col = 0. Go to STREAM when full[rd_bank] is set.
  - STREAM: each cycle, register column rd_col of bank rd_bank onto column_out, set valid_out = 1, and set last_out = (rd_col == MAT_WIDTH-1). Increment rd_col.
  - After the last column has been registered: clear full[rd_bank], toggle rd_bank, and reset rd_col to 0. Stay in STREAM if the other bank is already full; otherwise go to IDLE.
- In IDLE, valid_out and last_out are 0. column_out holds its last value, and its contents are don't-care when valid_out is 0.
- Data is transposed, never modified: column_out[m][r] at beat c equals the in_row[m][c] value accepted on row beat r of the same set.
- Matrix sets leave in the same order they arrived. Rows within a set are never mixed across banks.

## Timing
- Reset values: valid_out=0, last_out=0, column_out=all 0, both full flags=0, wr_bank=rd_bank=0, wr_row=rd_col=0, FSM=IDLE. in_ready=1 in the first cycle after reset.
- Latency: if the last row of a set is accepted at edge k, column 0 is presented after edge k+1, and column c is presented after edge k+1+c. last_out is high after edge k+MAT_WIDTH.
- Back-to-back sets: with both banks full, the next set's column 0 follows the previous set's last column with no bubble. valid_out stays high continuously.
- Bank release: the full flag clears at the edge that registers the last column. in_ready for that bank can therefore rise in the following cycle.
- Simultaneous events:
  - A write that completes bank X on the same edge the reader frees bank Y is legal, and both updates take effect.
  - The reader must not start on a bank at the same edge its full flag is set. The one-cycle latency above is mandatory.
- Full condition: both banks full gives in_ready=0. in_valid is ignored and no state changes on the write side.
- A partial set (wr_row ≠ 0) is held indefinitely. The bank is not emitted until its final row arrives.
- Reset asserted mid-operation: all stored and partial sets are discarded, and outputs return to reset values at that edge.

## Test plan
Defaults for all scenarios: N_MATS=10, MAT_HEIGHT=2, MAT_WIDTH=4. Element value = m·16 + r·4 + c for matrix m, row r, column c.
- Single set: 2 row beats, then idle → 4 valid_out beats starting 2 cycles after the second accept. Beat c gives column_out[m] = {m·16+c, m·16+4+c}. last_out is high only on beat 3. valid_out is 0 afterwards.
- Continuous input, in_valid held 1 for 3 sets → in_ready stays 1 for the first 4 beats. It drops when both banks are full and rises the cycle after bank 0 releases. valid_out stays high for 12 consecutive beats, and sets emerge in order.
- Stall: 5 set deliveries with in_valid toggling randomly → every column matches the transpose. No row is lost or duplicated. last_out count = 5.
- Full hold: fill both banks while the reader is streaming bank 0, then drive in_valid=1 with a marker value 0xDEAD → the marker is not stored while in_ready=0 and never appears on column_out.
- Partial set: 1 row beat only → valid_out stays 0 for 20 cycles. The second row beat then triggers normal output.
- Mid-stream reset: assert rst during beat 2 of a set → the next cycle shows valid_out=0, last_out=0, column_out=0, in_ready=1. A new set afterwards emits correctly with no remnants of the old one.
